// File: rtl/frame_buf_pkg.sv
// Shared constants for the frame buffer blocks: reset/enable polarities,
// scan-out FSM encoding and the marker bundle carried alongside each pixel.
package frame_buf_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRIME   = 3'd1;
  localparam logic [STATE_W-1:0] ST_ISSUE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT    = 3'd3;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd4;
  localparam logic [STATE_W-1:0] ST_GAP     = 3'd5;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

endpackage

// File: rtl/frame_rd_ctrl_pix_fifo.sv
// Small synchronous FIFO between the memory read path and the display stream.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pix_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                     pll0_pll_clk_clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

  always_ff @(posedge pll0_pll_clk_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge pll0_pll_clk_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/frame_rd_ctrl.sv
// Scan-out read controller: walks one frame of the frame buffer memory, one read
// outstanding at a time, and streams the pixels with sof/eol/eof markers.
module frame_rd_ctrl
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 29,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BASE_ADDR  = 0,
  parameter int READ_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  pll0_pll_clk_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_wr_active,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int H_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int V_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int LAT_W = $clog2(READ_LAT + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_WIDTH + 3;

  localparam logic [ADDR_WIDTH-1:0] PRIME_ADDR =
    ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(H_RES * V_RES) - ADDR_WIDTH'(1);
  localparam logic [STATE_W-1:0] ST_AFTER_ISSUE = (READ_LAT > 1) ? ST_WAIT : ST_CAPTURE;

  logic [STATE_W-1:0]    state;
  logic [H_W-1:0]        h;
  logic [V_W-1:0]        v;
  logic [LAT_W-1:0]      wait_cnt;
  logic                  prime_done;
  logic                  priming;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_head;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  issue_ok;
  logic                  last_h;
  logic                  last_v;
  logic [ADDR_WIDTH-1:0] pix_addr;
  pix_tag_t              push_tag;
  pix_tag_t              head_tag;

  assign issue_ok = (mem_wr_active == DEASSERT_H) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign last_h   = (h == H_W'(H_RES - 1));
  assign last_v   = (v == V_W'(V_RES - 1));
  assign pix_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(v) * ADDR_WIDTH'(H_RES)
                  + ADDR_WIDTH'(h);

  assign push_tag.sof = (h == '0) && (v == '0);
  assign push_tag.eol = last_h;
  assign push_tag.eof = last_h && last_v;

  // The address stays stable from issue through capture so the memory sees one read.
  always_comb begin
    rd_en   = DEASSERT_L;
    rd_addr = '0;
    case (state)
      ST_PRIME: begin
        if (issue_ok) begin
          rd_en   = ASSERT_L;
          rd_addr = PRIME_ADDR;
        end
      end
      ST_ISSUE: begin
        if (issue_ok) begin
          rd_en   = ASSERT_L;
          rd_addr = pix_addr;
        end
      end
      ST_WAIT, ST_CAPTURE: begin
        rd_en   = ASSERT_L;
        rd_addr = priming ? PRIME_ADDR : pix_addr;
      end
      default: begin
        rd_en   = DEASSERT_L;
        rd_addr = '0;
      end
    endcase
  end

  always_ff @(posedge pll0_pll_clk_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      h          <= '0;
      v          <= '0;
      wait_cnt   <= '0;
      prime_done <= 1'b0;
      priming    <= 1'b0;
      frame_done <= DEASSERT_H;
    end else begin
      frame_done <= fifo_pop && head_tag.eof;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (prime_done) begin
              state <= ST_ISSUE;
            end else begin
              priming <= 1'b1;
              state   <= ST_PRIME;
            end
          end
        end
        ST_PRIME, ST_ISSUE: begin
          if (issue_ok) begin
            wait_cnt <= LAT_W'(1);
            state    <= ST_AFTER_ISSUE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAT_W'(READ_LAT - 1)) begin
            state <= ST_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        ST_CAPTURE: begin
          state <= ST_GAP;
        end
        ST_GAP: begin
          state <= ST_ISSUE;
          if (priming) begin
            priming    <= 1'b0;
            prime_done <= 1'b1;
          end else if (last_h) begin
            h <= '0;
            if (last_v) begin
              v     <= '0;
              state <= ST_IDLE;
            end else begin
              v <= v + V_W'(1);
            end
          end else begin
            h <= h + H_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_push = (state == ST_CAPTURE) && !priming;
  assign fifo_pop  = pix_valid && pix_ready;

  pix_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .pll0_pll_clk_clk (pll0_pll_clk_clk),
    .reset            (reset),
    .push             (fifo_push),
    .push_data        ({rd_data, push_tag}),
    .pop              (fifo_pop),
    .head             (fifo_head),
    .empty            (fifo_empty),
    .count            (fifo_count)
  );

  assign head_tag  = pix_tag_t'(fifo_head[2:0]);
  assign pix_data  = fifo_head[FW-1:3];
  assign pix_valid = !fifo_empty;
  assign pix_sof   = pix_valid && head_tag.sof;
  assign pix_eol   = pix_valid && head_tag.eol;
  assign pix_eof   = pix_valid && head_tag.eof;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule
